// File: rtl/alu_mips_seq.sv
// rtl/alu_mips_seq.sv - registered MIPS ALU with iterative multiply/divide and valid/ready handshake
module alu_mips_seq #(
    parameter int WIDTH     = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_muldiv,
    input  logic [1:0]       in_op_type_1,
    input  logic [1:0]       in_op_type_2,
    input  logic             in_op_type_3,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_hi,
    output logic             out_slt,
    output logic             out_overflow,
    output logic             out_div0,
    output logic             out_illegal
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic             is_div;
    logic             neg_lo;
    logic             neg_hi;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opb;
    logic             accept;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    logic [WIDTH-1:0]        sc_result;
    logic                    sc_slt;
    logic                    sc_ovf;
    logic [WIDTH:0]          addsub;
    logic [SHW-1:0]          amt;
    logic [SHW:0]            ramt;
    logic signed [WIDTH-1:0] sar;

    always_comb begin
        sc_result = '0;
        sc_slt    = 1'b0;
        sc_ovf    = 1'b0;
        amt       = in_2[SHW-1:0];
        ramt      = (SHW+1)'(WIDTH) - {1'b0, amt};
        sar       = $signed(in_1) >>> amt;
        addsub    = in_op_type_2[0] ? ({1'b0, in_1} - {1'b0, in_2})
                                    : ({1'b0, in_1} + {1'b0, in_2});
        case (in_op_type_1)
            2'b11: begin
                case (in_op_type_2)
                    2'b00:   sc_result = in_1 & in_2;
                    2'b01:   sc_result = in_1 | in_2;
                    2'b10:   sc_result = ~(in_1 | in_2);
                    default: sc_result = in_1 ^ in_2;
                endcase
            end
            2'b10: begin
                sc_result = addsub[WIDTH-1:0];
                // Signed: operand signs decide; unsigned: bit WIDTH is carry (ADD) or borrow (SUB)
                if (is_signed)
                    sc_ovf = (in_op_type_2[0] ? (in_1[WIDTH-1] != in_2[WIDTH-1])
                                              : (in_1[WIDTH-1] == in_2[WIDTH-1]))
                             && (addsub[WIDTH-1] != in_1[WIDTH-1]);
                else
                    sc_ovf = addsub[WIDTH];
            end
            2'b01: begin
                sc_slt    = is_signed ? ($signed(in_1) < $signed(in_2)) : (in_1 < in_2);
                sc_result = {{(WIDTH-1){1'b0}}, sc_slt};
            end
            default: begin
                if (in_op_type_3) begin
                    case (in_op_type_2)
                        2'b01:   sc_result = (in_1 >> amt) | (in_1 << ramt);
                        2'b10:   sc_result = sar;
                        default: sc_result = in_1 >> amt;
                    endcase
                end else begin
                    if (in_op_type_2 == 2'b01)
                        sc_result = (in_1 << amt) | (in_1 >> ramt);
                    else
                        sc_result = in_1 << amt;
                end
            end
        endcase
    end

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        neg_a     = is_signed && in_1[WIDTH-1];
        neg_b     = is_signed && in_2[WIDTH-1];
        mag_a     = neg_a ? -in_1 : in_1;
        mag_b     = neg_b ? -in_2 : in_2;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        prod_fix  = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_fix   = neg_lo ? -acc_lo : acc_lo;
        rem_fix   = neg_hi ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            is_div       <= 1'b0;
            neg_lo       <= 1'b0;
            neg_hi       <= 1'b0;
            acc_hi       <= '0;
            acc_lo       <= '0;
            opb          <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_hi       <= '0;
            out_slt      <= 1'b0;
            out_overflow <= 1'b0;
            out_div0     <= 1'b0;
            out_illegal  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_hi       <= '0;
                        out_slt      <= 1'b0;
                        out_overflow <= 1'b0;
                        out_div0     <= 1'b0;
                        out_illegal  <= 1'b0;
                        if (!in_muldiv) begin
                            out_result   <= sc_result;
                            out_slt      <= sc_slt;
                            out_overflow <= sc_ovf;
                            out_valid    <= 1'b1;
                            state        <= DONE;
                        end else if (!MULDIV_EN) begin
                            out_result  <= '0;
                            out_illegal <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else if (in_op_type_2[0] && (in_2 == '0)) begin
                            out_result <= '1;
                            out_hi     <= in_1;
                            out_div0   <= 1'b1;
                            out_valid  <= 1'b1;
                            state      <= DONE;
                        end else begin
                            // Iterate on magnitudes; signs are reapplied once in DONE
                            is_div     <= in_op_type_2[0];
                            neg_lo     <= neg_a ^ neg_b;
                            neg_hi     <= neg_a;
                            acc_hi     <= '0;
                            acc_lo     <= mag_a;
                            opb        <= mag_b;
                            cnt        <= '0;
                            out_result <= '0;
                            out_valid  <= 1'b0;
                            state      <= BUSY;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                BUSY: begin
                    if (is_div) begin
                        if (!div_diff[WIDTH]) begin
                            acc_hi <= div_diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + SHW'(1);
                    if (cnt == LAST)
                        state <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_result <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
                        out_hi     <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                        out_valid  <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mips_seq.sv
// tb/tb_alu_mips_seq.sv - scoreboard bench for alu_mips_seq against a behavioural model
module tb_alu_mips_seq;
    typedef struct packed {
        logic        muldiv;
        logic [1:0]  t1;
        logic [1:0]  t2;
        logic        t3;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        slt;
        logic        ovf;
        logic        div0;
        logic        ill;
    } exp_t;

    typedef struct {
        exp_t e;
        int   acc;
        int   lat;
    } sb_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_muldiv;
    logic [1:0]  in_op_type_1;
    logic [1:0]  in_op_type_2;
    logic        in_op_type_3;
    logic        is_signed;
    logic [31:0] in_1;
    logic [31:0] in_2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_hi;
    logic        out_slt;
    logic        out_overflow;
    logic        out_div0;
    logic        out_illegal;

    alu_mips_seq #(.WIDTH(32), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_muldiv(in_muldiv), .in_op_type_1(in_op_type_1), .in_op_type_2(in_op_type_2),
        .in_op_type_3(in_op_type_3), .is_signed(is_signed), .in_1(in_1), .in_2(in_2),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_hi(out_hi),
        .out_slt(out_slt), .out_overflow(out_overflow), .out_div0(out_div0),
        .out_illegal(out_illegal)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cycle = 0;
    int   ready_mode = 1;
    logic mon_en = 1'b0;
    logic seen = 1'b0;
    logic held = 1'b0;
    logic [31:0] h_res;
    logic [31:0] h_hi;
    logic [3:0]  h_flags;
    sb_t  sb_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic req_t mk_req(input logic md, input logic [1:0] t1, input logic [1:0] t2,
                                    input logic t3, input logic sgn,
                                    input logic [31:0] a, input logic [31:0] b);
        req_t r;
        r.muldiv = md; r.t1 = t1; r.t2 = t2; r.t3 = t3; r.sgn = sgn; r.a = a; r.b = b;
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] res, input logic [31:0] hi,
                                    input logic slt, input logic ovf, input logic div0);
        exp_t e;
        e.res = res; e.hi = hi; e.slt = slt; e.ovf = ovf; e.div0 = div0; e.ill = 1'b0;
        return e;
    endfunction

    // Reference: widen to 64-bit integers and apply the arithmetic definitions directly
    function automatic exp_t model(input req_t r);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      s;
        logic [63:0] t;
        logic [31:0] x;
        int          amt;
        e   = '0;
        sa  = r.sgn ? longint'($signed(r.a)) : longint'({32'd0, r.a});
        sb  = r.sgn ? longint'($signed(r.b)) : longint'({32'd0, r.b});
        amt = int'(r.b[4:0]);
        x   = r.a;
        if (r.muldiv) begin
            if (!r.t2[0]) begin
                t = 64'(sa * sb);
                e.res = t[31:0]; e.hi = t[63:32];
            end else if (r.b == 32'd0) begin
                e.div0 = 1'b1; e.res = 32'hFFFF_FFFF; e.hi = r.a;
            end else begin
                t = 64'(sa / sb); e.res = t[31:0];
                t = 64'(sa % sb); e.hi = t[31:0];
            end
        end else begin
            case (r.t1)
                2'b11: begin
                    case (r.t2)
                        2'b00:   e.res = r.a & r.b;
                        2'b01:   e.res = r.a | r.b;
                        2'b10:   e.res = ~(r.a | r.b);
                        default: e.res = r.a ^ r.b;
                    endcase
                end
                2'b10: begin
                    s = r.t2[0] ? (sa - sb) : (sa + sb);
                    t = 64'(s);
                    e.res = t[31:0];
                    if (r.sgn)
                        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                    else
                        e.ovf = r.t2[0] ? (s < 0) : (s > 64'sd4294967295);
                end
                2'b01: begin
                    e.slt = (sa < sb);
                    e.res = {31'd0, e.slt};
                end
                default: begin
                    if (!r.t3) begin
                        if (r.t2 == 2'b01)
                            for (int k = 0; k < amt; k++) x = {x[30:0], x[31]};
                        else
                            x = x << amt;
                    end else begin
                        case (r.t2)
                            2'b01: for (int k = 0; k < amt; k++) x = {x[0], x[31:1]};
                            2'b10: begin
                                t = 64'(longint'($signed(r.a)) >>> amt);
                                x = t[31:0];
                            end
                            default: x = x >> amt;
                        endcase
                    end
                    e.res = x;
                end
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'd1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            5:       v = 32'($urandom_range(0, 40));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int   k;
        r.a = rand_opnd(); r.b = rand_opnd();
        r.sgn = 1'($urandom_range(0, 1)); r.t3 = 1'($urandom_range(0, 1));
        r.t1 = 2'($urandom_range(0, 3)); r.t2 = 2'($urandom_range(0, 3)); r.muldiv = 1'b0;
        k = $urandom_range(0, 9);
        if (k < 2) r.muldiv = 1'b1;
        else if (k < 4) r.t1 = 2'b11;
        else if (k < 6) begin r.t1 = 2'b10; r.t2[1] = 1'b0; end
        else if (k == 6) r.t1 = 2'b01;
        else begin r.t1 = 2'b00; r.t2 = 2'($urandom_range(0, 2)); end
        return r;
    endfunction

    task automatic drive(input req_t r);
        in_muldiv = r.muldiv; in_op_type_1 = r.t1; in_op_type_2 = r.t2; in_op_type_3 = r.t3;
        is_signed = r.sgn; in_1 = r.a; in_2 = r.b; in_valid = 1'b1;
    endtask

    task automatic issue(input req_t r, input exp_t e);
        sb_t ent;
        int  waited;
        bit  done;
        waited = 0;
        done   = 1'b0;
        drive(r);
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                ent.e   = e;
                ent.acc = cycle + 1;
                ent.lat = (r.muldiv && !(r.t2[0] && r.b == 32'd0)) ? 33 : 0;
                sb_q.push_back(ent);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 500) begin
                    n_cmp++; n_bad++;
                    $display("FAIL accept_timeout: in_ready low for 500 cycles, expected high");
                    in_valid = 1'b0;
                    done = 1'b1;
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (held) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_result", out_result, h_res);
                    chk("hold_hi", out_hi, h_hi);
                    chk("hold_flags", 32'({out_slt, out_overflow, out_div0, out_illegal}), 32'(h_flags));
                    held = 1'b0;
                end
                if (out_valid) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_valid", 32'(out_valid), 32'd0);
                    end else begin
                        if (!seen) begin
                            chk("latency", 32'(cycle), 32'(sb_q[0].acc + sb_q[0].lat));
                            seen = 1'b1;
                        end
                        if (out_ready) begin
                            chk("result", out_result, sb_q[0].e.res);
                            chk("hi", out_hi, sb_q[0].e.hi);
                            chk("flags", 32'({out_slt, out_overflow, out_div0, out_illegal}),
                                32'({sb_q[0].e.slt, sb_q[0].e.ovf, sb_q[0].e.div0, sb_q[0].e.ill}));
                            void'(sb_q.pop_front());
                            seen = 1'b0;
                        end else begin
                            held    = 1'b1;
                            h_res   = out_result;
                            h_hi    = out_hi;
                            h_flags = {out_slt, out_overflow, out_div0, out_illegal};
                        end
                    end
                end else if (sb_q.size() > 0 && cycle >= sb_q[0].acc) begin
                    chk("busy_in_ready", 32'(in_ready), 32'd0);
                end
            end
        end
    end

    initial begin
        req_t r;
        reset = 1'b1; in_valid = 1'b0; in_muldiv = 1'b0; in_op_type_1 = 2'b00;
        in_op_type_2 = 2'b00; in_op_type_3 = 1'b0; is_signed = 1'b0; in_1 = '0; in_2 = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_result", out_result, 32'd0);
        chk("rst_hi", out_hi, 32'd0);
        chk("rst_flags", 32'({out_slt, out_overflow, out_div0, out_illegal}), 32'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        issue(mk_req(0, 2'b10, 2'b00, 0, 0, 32'd3000000000, 32'd4000000000),
              mk_exp(32'hA13B_8600, 0, 0, 1, 0));
        issue(mk_req(0, 2'b10, 2'b00, 0, 1, 32'd2000000000, 32'd2000000000),
              mk_exp(32'hEE6B_2800, 0, 0, 1, 0));
        issue(mk_req(0, 2'b10, 2'b01, 0, 1, 32'd25, 32'd50), mk_exp(32'hFFFF_FFE7, 0, 0, 0, 0));
        issue(mk_req(0, 2'b10, 2'b01, 0, 0, 32'd1, 32'd2), mk_exp(32'hFFFF_FFFF, 0, 0, 1, 0));
        issue(mk_req(0, 2'b00, 2'b01, 1, 0, 32'hF800_007C, 32'd4), mk_exp(32'hCF80_0007, 0, 0, 0, 0));
        issue(mk_req(0, 2'b00, 2'b10, 1, 0, 32'hF800_007C, 32'd4), mk_exp(32'hFF80_0007, 0, 0, 0, 0));
        issue(mk_req(0, 2'b00, 2'b00, 0, 0, 32'hF800_007C, 32'hFFFF_FFE5), mk_exp(32'h0000_0F80, 0, 0, 0, 0));
        issue(mk_req(0, 2'b01, 2'b00, 0, 1, 32'hFFFF_FFFF, 32'd1), mk_exp(32'd1, 0, 1, 0, 0));
        issue(mk_req(0, 2'b01, 2'b00, 0, 0, 32'hFFFF_FFFF, 32'd1), mk_exp(32'd0, 0, 0, 0, 0));
        issue(mk_req(1, 2'b00, 2'b00, 0, 1, 32'hFFFF_FFFD, 32'd5),
              mk_exp(32'hFFFF_FFF1, 32'hFFFF_FFFF, 0, 0, 0));
        issue(mk_req(1, 2'b00, 2'b01, 0, 1, 32'hFFFF_FFF9, 32'd2),
              mk_exp(32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0, 0));
        issue(mk_req(1, 2'b00, 2'b01, 0, 0, 32'd9, 32'd0), mk_exp(32'hFFFF_FFFF, 32'd9, 0, 0, 1));
        issue(mk_req(1, 2'b00, 2'b01, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF),
              mk_exp(32'h8000_0000, 32'd0, 0, 0, 0));

        repeat (40) begin @(posedge clk); #1; end
        ready_mode = 2;
        @(posedge clk);
        #1;
        issue(mk_req(0, 2'b10, 2'b00, 0, 0, 32'd1, 32'd2), mk_exp(32'd3, 0, 0, 0, 0));
        r = mk_req(0, 2'b11, 2'b11, 0, 0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        drive(r);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_blocks_input", 32'(in_ready), 32'd0);
        end
        ready_mode = 1;
        issue(r, model(r));

        issue(mk_req(1, 2'b00, 2'b00, 0, 0, 32'd7, 32'd9), mk_exp(32'd63, 0, 0, 0, 0));
        repeat (9) @(posedge clk);
        #1;
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        seen = 1'b0;
        held = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (40) @(negedge clk);
        chk("abort_discarded", 32'(out_valid), 32'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        ready_mode = 0;
        for (int i = 0; i < 300; i++) begin
            r = rand_req();
            issue(r, model(r));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        ready_mode = 1;
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
